input_port_unit: RTL and testbench
==================================

INPUT_PORT_UNIT -- requirements
Module: input_port_unit

Interface
REQ-001 SHALL have parameter WIDTH, default 16: data width of the port and pipeline word.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries, power of two, minimum 2.
REQ-003 SHALL have port clk, input, 1: sole clock, rising-edge.
REQ-004 SHALL have port rst, input, 1: reset, asynchronous, active-high.
REQ-005 SHALL have port in_valid, input, 1: external device offers in_data this cycle.
REQ-006 SHALL have port in_data, input, WIDTH: external port word.
REQ-007 SHALL have port in_ready, output, 1: unit accepts a word this cycle.
REQ-008 SHALL have port rd_req, input, 1: an IN instruction requests a port word this cycle.
REQ-009 SHALL have port rd_data, output, WIDTH: head-of-FIFO word, routed to the write-back data mux.
REQ-010 SHALL have port rd_ack, output, 1: rd_req serviced this cycle; the head is popped at the next edge.
REQ-011 SHALL have port stall, output, 1: rd_req asserted with FIFO empty; the pipeline holds the IN instruction.
REQ-012 SHALL have port count, output, log2(DEPTH)+1: current occupancy.

Function
REQ-013 SHALL implement a DEPTH-entry circular FIFO with write pointer, read pointer and occupancy counter.
REQ-014 SHALL drive in_ready = (count < DEPTH) and not rst.
REQ-015 SHALL push: on a rising edge with in_valid and in_ready, write in_data at the write pointer, advance it modulo DEPTH, and increment count.
REQ-016 SHALL drive rd_data combinationally from the read-pointer entry (first-word fall-through); rd_data is don't-care when count = 0.
REQ-017 SHALL drive rd_ack = rd_req and (count > 0), combinationally.
REQ-018 SHALL drive stall = rd_req and (count = 0), combinationally; rd_ack and stall SHALL never both be 1.
REQ-019 SHALL pop: on a rising edge with rd_ack, advance the read pointer modulo DEPTH and decrement count.
REQ-020 SHALL, on a simultaneous push and pop, keep count unchanged and advance both pointers.
REQ-021 SHALL hold in_ready at 0 when full, even if a pop occurs in the same cycle; the freed slot is offered from the next cycle.
REQ-022 SHALL, when empty, reject the pop while accepting the push in a simultaneous push and rd_req cycle: stall = 1 that cycle; the pushed word appears on rd_data the following cycle.
REQ-023 SHALL wrap both pointers from DEPTH-1 to 0 with no lost or duplicated words.
REQ-024 SHALL leave in_data and rd_req unsampled when the corresponding handshake is not completed.
REQ-025 SHALL have latency of one clock from accepted push to visibility on rd_data/count.
REQ-026 SHALL hold stored entries when neither push nor pop occurs.

Reset
REQ-027 SHALL, while rst = 1, immediately force read pointer = 0, write pointer = 0, count = 0, and in_ready = 0, with stall = rd_req and rd_ack = 0.
REQ-028 SHALL, when rst asserts mid-operation, discard all buffered words; no push or pop SHALL complete on an edge where rst = 1.
REQ-029 SHALL NOT require FIFO storage contents to be reset.
REQ-030 SHALL assert in_ready = 1 in the first cycle after rst deasserts.

Verification
REQ-031 SHALL cover basic transfer: push 0x1234, then rd_req next cycle -> rd_data = 0x1234, rd_ack = 1, stall = 0; count 1 -> 0.
REQ-032 SHALL cover full: push 0xA000..0xA003 back-to-back -> count = 4, in_ready = 0; a fifth in_valid is ignored; pops return A000, A001, A002, A003 in order.
REQ-033 SHALL cover empty stall: rd_req with count = 0 -> stall = 1, rd_ack = 0, count stays 0; a push of 0x00FF that same cycle -> next cycle rd_data = 0x00FF, stall = 0.
REQ-034 SHALL cover wrap and concurrency: 10 cycles of simultaneous push/pop at count = 2 -> count stays 2, all data in order across pointer wrap.
REQ-035 SHALL cover full with pop: at count = 4, rd_req with in_valid -> pop only, count = 3, in_ready = 1 next cycle.
REQ-036 SHALL cover async reset: rst pulse between edges with count = 3 -> count = 0 and in_ready = 0 without a clock edge; after release, in_ready = 1 and the old data is never returned.

Source files
------------

// File: rtl/input_port_unit.sv
// input_port_unit: DEPTH-entry first-word-fall-through FIFO between an external input port and the IN instruction
//   in_valid/in_data/in_ready : push handshake from the external device
//   rd_req                    : IN instruction wants a word this cycle
//   rd_data                   : head word, valid when rd_ack = 1
//   rd_ack / stall            : request serviced / request blocked on an empty FIFO
//   count                     : current occupancy, 0..DEPTH
module input_port_unit #(
  parameter int WIDTH = 16,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     in_valid,
  input  logic [WIDTH-1:0]         in_data,
  output logic                     in_ready,
  input  logic                     rd_req,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     rd_ack,
  output logic                     stall,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wp, rp;
  logic             push, empty;
  // DEPTH is a power of two, so the count MSB alone flags full
  always_comb begin
    empty    = count == '0;
    in_ready = !count[AW] && !rst;
    rd_ack   = rd_req && !empty;
    stall    = rd_req && empty;
    push     = in_valid && in_ready;
    rd_data  = mem[rp];
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      wp    <= '0;
      rp    <= '0;
      count <= '0;
    end else begin
      if (push) wp <= wp + AW'(1);
      if (rd_ack) rp <= rp + AW'(1);
      count <= count + (AW+1)'(push) - (AW+1)'(rd_ack);
    end
  always_ff @(posedge clk)
    if (push) mem[wp] <= in_data;
endmodule

// File: tb/tb_input_port_unit.sv
// tb_input_port_unit: directed scoreboard bench for input_port_unit
module tb_input_port_unit;
  logic        clk = 0;
  logic        rst = 1;
  logic        in_valid = 0;
  logic [15:0] in_data = '0;
  logic        in_ready;
  logic        rd_req = 0;
  logic [15:0] rd_data;
  logic        rd_ack;
  logic        stall;
  logic [2:0]  count;
  int          n_vec = 0;
  int          n_bad = 0;
  logic [15:0] exp_q [$];

  input_port_unit #(.WIDTH(16), .DEPTH(4)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .rd_req(rd_req), .rd_data(rd_data), .rd_ack(rd_ack), .stall(stall), .count(count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // monitor: every serviced read must match the oldest expected word
  always @(negedge clk)
    if (rd_ack) begin
      if (exp_q.size() == 0) chk("unexpected_ack", 32'(rd_data), 32'hxxxx_xxxx);
      else chk("rd_data", 32'(rd_data), 32'(exp_q.pop_front()));
    end

  task automatic step(input logic v, input logic [15:0] d, input logic r,
                      input logic ack, input logic [15:0] word,
                      input logic [2:0] cnt, input logic rdy);
    @(posedge clk);
    #1;
    in_valid = v;
    in_data  = d;
    rd_req   = r;
    if (ack) exp_q.push_back(word);
    #1;
    chk("count", 32'(count), 32'(cnt));
    chk("in_ready", 32'(in_ready), 32'(rdy));
    chk("rd_ack", 32'(rd_ack), 32'(ack));
    chk("stall", 32'(stall), 32'(r && !ack));
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end

  initial begin
    rd_req = 1;
    #2;
    chk("rst_count", 32'(count), 0);
    chk("rst_in_ready", 32'(in_ready), 0);
    chk("rst_rd_ack", 32'(rd_ack), 0);
    chk("rst_stall", 32'(stall), 1);
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 0;
    rd_req = 0;
    #1;
    chk("post_rst_in_ready", 32'(in_ready), 1);
    // basic transfer
    step(1, 16'h1234, 0, 0, 16'h0, 3'd0, 1);
    step(0, 16'h0,    1, 1, 16'h1234, 3'd1, 1);
    // empty stall with simultaneous push
    step(1, 16'h00FF, 1, 0, 16'h0, 3'd0, 1);
    step(0, 16'h0,    1, 1, 16'h00FF, 3'd1, 1);
    // fill to full, fifth word ignored
    step(1, 16'hA000, 0, 0, 16'h0, 3'd0, 1);
    step(1, 16'hA001, 0, 0, 16'h0, 3'd1, 1);
    step(1, 16'hA002, 0, 0, 16'h0, 3'd2, 1);
    step(1, 16'hA003, 0, 0, 16'h0, 3'd3, 1);
    step(1, 16'hBEEF, 0, 0, 16'h0, 3'd4, 0);
    // full with pop: only the pop completes
    step(1, 16'hCCCC, 1, 1, 16'hA000, 3'd4, 0);
    step(0, 16'h0,    1, 1, 16'hA001, 3'd3, 1);
    step(0, 16'h0,    1, 1, 16'hA002, 3'd2, 1);
    step(0, 16'h0,    1, 1, 16'hA003, 3'd1, 1);
    step(0, 16'h0,    0, 0, 16'h0, 3'd0, 1);
    // concurrent push/pop at count 2 across pointer wrap
    step(1, 16'h5000, 0, 0, 16'h0, 3'd0, 1);
    step(1, 16'h5001, 0, 0, 16'h0, 3'd1, 1);
    for (int i = 0; i < 10; i++)
      step(1, 16'h5002 + 16'(i), 1, 1, 16'h5000 + 16'(i), 3'd2, 1);
    step(0, 16'h0, 1, 1, 16'h500A, 3'd2, 1);
    step(0, 16'h0, 1, 1, 16'h500B, 3'd1, 1);
    // async reset with three words buffered
    step(1, 16'h7000, 0, 0, 16'h0, 3'd0, 1);
    step(1, 16'h7001, 0, 0, 16'h0, 3'd1, 1);
    step(1, 16'h7002, 0, 0, 16'h0, 3'd2, 1);
    @(posedge clk);
    #1;
    in_valid = 0;
    #1;
    chk("pre_rst_count", 32'(count), 3);
    #1;
    rst = 1;
    rd_req = 1;
    #1;
    chk("async_rst_count", 32'(count), 0);
    chk("async_rst_in_ready", 32'(in_ready), 0);
    chk("async_rst_stall", 32'(stall), 1);
    chk("async_rst_rd_ack", 32'(rd_ack), 0);
    #2;
    rst = 0;
    rd_req = 0;
    #1;
    chk("rel_in_ready", 32'(in_ready), 1);
    step(0, 16'h0,    1, 0, 16'h0, 3'd0, 1);
    step(1, 16'h7777, 0, 0, 16'h0, 3'd0, 1);
    step(0, 16'h0,    1, 1, 16'h7777, 3'd1, 1);
    step(0, 16'h0,    0, 0, 16'h0, 3'd0, 1);
    @(posedge clk);
    @(posedge clk);
    chk("scoreboard_drained", 32'(exp_q.size()), 0);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
